// File: rtl/exp_rom_loader_if.sv
// ----------------------------------------------------------------------------
// exp_rom_loader_if
// Purpose : bundles the hps_io ioctl download stream and the SDRAM boot write
//           port that the ROM loader sits between.
// Signals :
//   ioctl_wr / ioctl_addr / ioctl_dout : byte strobe, file offset, data (host)
//   ioctl_wait                          : loader busy, host holds next strobe
//   mem_wr / mem_addr / mem_bank / mem_din : SDRAM write request (loader)
// Modports:
//   master : host / SDRAM side (drives ioctl_*, observes ioctl_wait and mem_*)
//   slave  : the loader
// Handshake: a byte is offered by a one-cycle ioctl_wr while ioctl_wait is low;
//   once accepted, ioctl_wait stays high until the byte is committed, and any
//   ioctl_wr seen in the meantime is ignored. mem_wr is a level request held
//   for whole ce_ref intervals with mem_addr/mem_bank/mem_din stable under it.
// ----------------------------------------------------------------------------
interface exp_rom_loader_if #(
  parameter int ADDR_W = 23,
  parameter int BANK_W = 1
);
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [BANK_W-1:0] mem_bank;
  logic [7:0]        mem_din;

  modport master (
    output ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait, mem_wr, mem_addr, mem_bank, mem_din
  );

  modport slave (
    input  ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait, mem_wr, mem_addr, mem_bank, mem_din
  );
endinterface

// File: rtl/exp_rom_loader.sv
// ----------------------------------------------------------------------------
// exp_rom_loader
// Purpose : loads a downloaded expansion/firmware ROM file into SDRAM. Each
//           16 KB chunk of the file maps to one SDRAM page counted from a
//           per-download base page; every byte is paced onto ce_ref memory
//           slots and optionally replicated into all banks. A per-page bitmap
//           records which ROM-region pages hold data.
// Ports   :
//   clk_sys, reset      : clock, asynchronous active-high reset
//   ce_ref              : memory slot strobe (one clk_sys wide)
//   dl_start            : download start pulse; latches dl_page_base,
//                         dl_all_banks, dl_combo; aborts any byte in flight
//   bus (slave)         : ioctl download stream in, SDRAM write port out
//   map_clear           : clear the whole ROM-present bitmap
//   map_rd_page         : bitmap lookup index
//   map_rd_valid        : bitmap[map_rd_page], one cycle later
//   byte_count          : bytes committed since dl_start (saturating)
//   overflow            : sticky, a byte beyond MAX_CHUNKS was dropped
//   dbg_state           : current FSM state (IDLE=0, SLOT=1, WRITE=2)
// ----------------------------------------------------------------------------
module exp_rom_loader #(
  parameter int ADDR_W     = 23,
  parameter int PAGE_W     = 8,
  parameter int NBANKS     = 2,
  parameter int MAX_CHUNKS = 16,
  localparam int BANK_W    = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_ref,
  input  logic              dl_start,
  input  logic [PAGE_W:0]   dl_page_base,
  input  logic              dl_all_banks,
  input  logic              dl_combo,
  exp_rom_loader_if.slave   bus,
  input  logic              map_clear,
  input  logic [PAGE_W-1:0] map_rd_page,
  output logic              map_rd_valid,
  output logic [23:0]       byte_count,
  output logic              overflow,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SLOT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_wait;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [BANK_W-1:0]   r_bank;
  logic [7:0]          r_din;
  logic [PAGE_W:0]     r_base;
  logic                r_all_banks;
  logic                r_combo;
  logic [(2**PAGE_W)-1:0] r_bitmap;
  logic                r_map_rd_valid;
  logic [23:0]         r_byte_count;
  logic                r_overflow;

  logic [10:0]         w_chunk;
  logic                w_in_range;
  logic                w_region;
  logic [PAGE_W-1:0]   w_page;
  logic                w_last_bank;
  logic [PAGE_W-1:0]   w_commit_page;
  logic                w_commit_region;

  assign w_chunk    = bus.ioctl_addr[24:14];
  assign w_in_range = (w_chunk < 11'(MAX_CHUNKS));

  // Chunk-to-page mapping. The page adds modulo 2^PAGE_W; the region bit is
  // taken from the base and never receives a carry. In combo mode chunk 0
  // goes to the base page and later chunks fill the ROM region from page 0.
  always_comb begin
    w_region = r_base[PAGE_W];
    w_page   = r_base[PAGE_W-1:0] + PAGE_W'(w_chunk);
    if (r_combo && (w_chunk != 11'd0)) begin
      w_region = 1'b1;
      w_page   = PAGE_W'(w_chunk - 11'd1);
    end
  end

  // The page being committed is recovered from the held write address.
  assign w_commit_region = r_addr[ADDR_W-1];
  assign w_commit_page   = r_addr[ADDR_W-2:14];
  assign w_last_bank     = !r_all_banks || (r_bank == BANK_W'(NBANKS - 1));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wait         <= 1'b0;
      r_mem_wr       <= 1'b0;
      r_addr         <= '0;
      r_bank         <= '0;
      r_din          <= '0;
      r_base         <= '0;
      r_all_banks    <= 1'b0;
      r_combo        <= 1'b0;
      r_bitmap       <= '0;
      r_map_rd_valid <= 1'b0;
      r_byte_count   <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_map_rd_valid <= r_bitmap[map_rd_page];

      if (dl_start) begin
        // New download: drop any byte in flight, keep the bitmap.
        r_state      <= S_IDLE;
        r_mem_wr     <= 1'b0;
        r_wait       <= 1'b0;
        r_byte_count <= '0;
        r_overflow   <= 1'b0;
        r_base       <= dl_page_base;
        r_all_banks  <= dl_all_banks;
        r_combo      <= dl_combo;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.ioctl_wr) begin
              if (!w_in_range) begin
                r_overflow <= 1'b1;
              end else begin
                r_din   <= bus.ioctl_dout;
                r_addr  <= {w_region, w_page, bus.ioctl_addr[13:0]};
                r_bank  <= '0;
                r_wait  <= 1'b1;
                r_state <= S_SLOT;
              end
            end
          end
          S_SLOT: begin
            if (ce_ref) begin
              r_mem_wr <= 1'b1;
              r_state  <= S_WRITE;
            end
          end
          S_WRITE: begin
            if (ce_ref) begin
              if (!w_last_bank) begin
                r_bank <= r_bank + BANK_W'(1);
              end else begin
                r_mem_wr <= 1'b0;
                r_wait   <= 1'b0;
                r_state  <= S_IDLE;
                if (r_byte_count != 24'hFFFFFF) begin
                  r_byte_count <= r_byte_count + 24'd1;
                end
                if (w_commit_region) begin
                  r_bitmap[w_commit_page] <= 1'b1;
                end
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end

      // Placed last so a clear wins over a set landing in the same cycle.
      if (map_clear) begin
        r_bitmap <= '0;
      end
    end
  end

  assign bus.ioctl_wait = r_wait;
  assign bus.mem_wr     = r_mem_wr;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_bank   = r_bank;
  assign bus.mem_din    = r_din;
  assign map_rd_valid   = r_map_rd_valid;
  assign byte_count     = r_byte_count;
  assign overflow       = r_overflow;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_exp_rom_loader.sv
// ----------------------------------------------------------------------------
// tb_exp_rom_loader
// Directed bench for exp_rom_loader (default parameters: ADDR_W=23, PAGE_W=8,
// NBANKS=2, MAX_CHUNKS=16). A file-level model computes each byte's SDRAM
// address from offset/base/combo rules and queues the expected write
// intervals; a negedge compare process checks every write interval and the
// stability of the write port while mem_wr is held.
// ----------------------------------------------------------------------------
module tb_exp_rom_loader;

  localparam int ADDR_W = 23;
  localparam int PAGE_W = 8;
  localparam int NBANKS = 2;
  localparam int W      = ADDR_W + 1 + 8;  // {addr, bank, data}

  logic              clk_sys;
  logic              reset;
  logic              ce_ref;
  logic              dl_start;
  logic [PAGE_W:0]   dl_page_base;
  logic              dl_all_banks;
  logic              dl_combo;
  logic              map_clear;
  logic [PAGE_W-1:0] map_rd_page;
  logic              map_rd_valid;
  logic [23:0]       byte_count;
  logic              overflow;
  logic [1:0]        dbg_state;

  exp_rom_loader_if #(.ADDR_W(ADDR_W), .BANK_W(1)) bus ();

  exp_rom_loader #(
    .ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .NBANKS(NBANKS), .MAX_CHUNKS(16)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ce_ref       (ce_ref),
    .dl_start     (dl_start),
    .dl_page_base (dl_page_base),
    .dl_all_banks (dl_all_banks),
    .dl_combo     (dl_combo),
    .bus          (bus),
    .map_clear    (map_clear),
    .map_rd_page  (map_rd_page),
    .map_rd_valid (map_rd_valid),
    .byte_count   (byte_count),
    .overflow     (overflow),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / slot strobe ----------------
  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  int ce_cnt;
  initial begin
    ce_ref = 1'b0;
    ce_cnt = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      ce_cnt = (ce_cnt + 1) % 4;
      ce_ref = (ce_cnt == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  // ---------------- model and scoreboard ----------------
  int n_pass;
  int n_total;
  logic [W-1:0] exp_q[$];

  int m_base;
  bit m_all;
  bit m_combo;
  int m_count;
  bit m_overflow;
  bit m_bitmap[256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int model_addr(input int a);
    int chunk, off, region, page;
    chunk = a / 16384;
    off   = a % 16384;
    if (m_combo && chunk > 0) begin
      region = 1;
      page   = (chunk - 1) % 256;
    end else begin
      region = m_base / 256;
      page   = ((m_base % 256) + chunk) % 256;
    end
    return region * 4194304 + page * 16384 + off;
  endfunction

  // compare process: one expected entry per write interval (bank)
  logic              prev_wr;
  logic [0:0]        prev_bank;
  logic [ADDR_W-1:0] prev_addr;
  logic [7:0]        prev_din;
  initial begin
    logic [W-1:0] e;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev_wr = 1'b0;
      end else begin
        if (bus.mem_wr) begin
          if (!prev_wr || bus.mem_bank != prev_bank) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_write", 32'(bus.mem_addr), 32'hFFFFFFFF);
            end else begin
              e = exp_q.pop_front();
              chk("wr_addr", 32'(bus.mem_addr), 32'(e[W-1:9]));
              chk("wr_bank", 32'(bus.mem_bank), 32'(e[8]));
              chk("wr_din",  32'(bus.mem_din),  32'(e[7:0]));
            end
          end else begin
            chk("wr_addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
            chk("wr_din_stable",  32'(bus.mem_din),  32'(prev_din));
          end
        end
        prev_wr   = bus.mem_wr;
        prev_bank = bus.mem_bank;
        prev_addr = bus.mem_addr;
        prev_din  = bus.mem_din;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_dl_start(input int base, input bit all, input bit combo);
    @(posedge clk_sys); #1;
    dl_start = 1'b1; dl_page_base = 9'(base); dl_all_banks = all; dl_combo = combo;
    @(posedge clk_sys); #1;
    dl_start = 1'b0;
    m_base = base; m_all = all; m_combo = combo; m_count = 0; m_overflow = 0;
    @(negedge clk_sys);
    chk("start_count", 32'(byte_count), 32'(m_count));
    chk("start_overflow", 32'(overflow), 32'(m_overflow));
  endtask

  task automatic do_map_clear();
    @(posedge clk_sys); #1 map_clear = 1'b1;
    @(posedge clk_sys); #1 map_clear = 1'b0;
    foreach (m_bitmap[i]) m_bitmap[i] = 0;
  endtask

  task automatic check_map(input int page, input int lit);
    @(posedge clk_sys); #1 map_rd_page = 8'(page);
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("map_model", 32'(map_rd_valid), 32'(m_bitmap[page]));
    chk("map_literal", 32'(map_rd_valid), 32'(lit));
  endtask

  // Offers one byte and follows it to commit. pin >= 0 is a hand-computed
  // address; clr raises map_clear in the commit cycle.
  task automatic send_byte(input int a, input int d, input int pin, input bit clr);
    int chunk, ea, nb, n, page;
    bit done, seen;
    logic [ADDR_W-1:0] got;
    chunk = a / 16384;
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(a); bus.ioctl_dout = 8'(d);
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b0;
    if (chunk >= 16) begin
      m_overflow = 1;
      @(negedge clk_sys);
      chk("drop_wait", 32'(bus.ioctl_wait), 32'd0);
      chk("drop_overflow", 32'(overflow), 32'(m_overflow));
      chk("drop_count", 32'(byte_count), 32'(m_count));
      repeat (12) @(negedge clk_sys);
      chk("drop_no_wr", 32'(bus.mem_wr), 32'd0);
      return;
    end
    ea = model_addr(a);
    nb = m_all ? NBANKS : 1;
    for (int b = 0; b < nb; b++) exp_q.push_back({ADDR_W'(ea), 1'(b), 8'(d)});
    @(negedge clk_sys);
    chk("wait_rise", 32'(bus.ioctl_wait), 32'd1);
    n = 0; done = 0; seen = 0; got = '0;
    for (int g = 0; g < 400 && !done; g++) begin
      if (ce_ref) begin
        n++;
        if (clr && n == 1 + nb) map_clear = 1'b1;
      end
      @(negedge clk_sys);
      map_clear = 1'b0;
      if (bus.mem_wr && !seen) begin seen = 1; got = bus.mem_addr; end
      if (!bus.ioctl_wait) done = 1;
    end
    if (!done) begin
      chk("wait_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency_ce", 32'(n), 32'(1 + nb));
    if (pin >= 0) chk("addr_literal", 32'(got), 32'(pin));
    if (m_count < 24'hFFFFFF) m_count++;
    page = (ea / 16384) % 256;
    if (clr) foreach (m_bitmap[i]) m_bitmap[i] = 0;
    else if (ea / 4194304 == 1) m_bitmap[page] = 1;
    chk("byte_count", 32'(byte_count), 32'(m_count));
  endtask

  task automatic wait_mem_wr(output bit ok);
    ok = 0;
    for (int g = 0; g < 100 && !ok; g++) begin
      @(negedge clk_sys);
      if (bus.mem_wr) ok = 1;
    end
    if (!ok) chk("mem_wr_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    n_pass = 0; n_total = 0;
    reset = 1'b1; dl_start = 1'b0; dl_page_base = '0; dl_all_banks = 1'b0;
    dl_combo = 1'b0; map_clear = 1'b0; map_rd_page = '0;
    bus.ioctl_wr = 1'b0; bus.ioctl_addr = '0; bus.ioctl_dout = '0;
    m_base = 0; m_all = 0; m_combo = 0; m_count = 0; m_overflow = 0;
    foreach (m_bitmap[i]) m_bitmap[i] = 0;

    repeat (3) @(negedge clk_sys);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_count", 32'(byte_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_map", 32'(map_rd_valid), 32'd0);
    @(posedge clk_sys); #1 reset = 1'b0;

    // single bank, base {1,0x00}
    do_dl_start('h100, 0, 0);
    send_byte('h0005, 'hA5, 'h400005, 0);
    chk("count_one", 32'(byte_count), 32'd1);
    check_map('h00, 1);

    // replicate into both banks, base {1,0x07}
    do_dl_start('h107, 1, 0);
    send_byte('h3FFF, 'h3C, 'h41FFFF, 0);
    check_map('h07, 1);

    // page wraps, region bit is kept
    do_dl_start('h1FF, 0, 0);
    send_byte('h4000, 'h5A, 'h400000, 0);

    // combo file
    do_map_clear();
    do_dl_start('h000, 0, 1);
    send_byte('h0000, 'h11, 'h000000, 0);
    send_byte('h8000, 'h22, 'h404000, 0);
    check_map('h01, 1);
    check_map('h00, 0);

    // chunk 16 is beyond MAX_CHUNKS
    send_byte('h40000, 'h77, -1, 0);
    chk("overflow_set", 32'(overflow), 32'd1);
    do_dl_start('h000, 0, 1);
    chk("overflow_cleared", 32'(overflow), 32'd0);

    // abort a byte mid-write with dl_start
    do_dl_start('h100, 0, 0);
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0042; bus.ioctl_dout = 8'h66;
    exp_q.push_back({ADDR_W'(model_addr('h42)), 1'b0, 8'h66});
    @(posedge clk_sys); #1 bus.ioctl_wr = 1'b0;
    wait_mem_wr(ok);
    dl_start = 1'b1; dl_page_base = 9'h100; dl_all_banks = 1'b0; dl_combo = 1'b0;
    @(posedge clk_sys); #1 dl_start = 1'b0;
    m_count = 0; m_overflow = 0;
    @(negedge clk_sys);
    chk("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("abort_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("abort_count", 32'(byte_count), 32'd0);
    check_map('h00, 0);

    // clear wins over a set landing in the same cycle
    send_byte('h0010, 'h81, 'h400010, 0);
    check_map('h00, 1);
    send_byte('h0123, 'h99, 'h400123, 1);
    check_map('h00, 0);
    check_map('h01, 0);

    // asynchronous reset during a write
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'h0200; bus.ioctl_dout = 8'hC3;
    exp_q.push_back({ADDR_W'(model_addr('h200)), 1'b0, 8'hC3});
    @(posedge clk_sys); #1 bus.ioctl_wr = 1'b0;
    wait_mem_wr(ok);
    #2 reset = 1'b1;
    #1;
    chk("arst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("arst_wait", 32'(bus.ioctl_wait), 32'd0);
    chk("arst_addr", 32'(bus.mem_addr), 32'd0);
    chk("arst_din", 32'(bus.mem_din), 32'd0);
    chk("arst_count", 32'(byte_count), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    foreach (m_bitmap[i]) m_bitmap[i] = 0;
    m_count = 0; m_overflow = 0; m_base = 0; m_all = 0; m_combo = 0;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    check_map('h00, 0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
